// File: rtl/dmem_arbiter.sv
// Data memory arbiter between the pipeline and the debug/loader port.
// One access in flight at a time; round-robin on ties; aborts after TIMEOUT wait cycles.
module dmem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  input  logic [2:0]  p_xfer,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_xfer,
  output logic        p_gnt,
  output logic        d_gnt,
  output logic        p_done,
  output logic        d_done,
  output logic        p_err,
  output logic        d_err,
  output logic [31:0] p_rdata,
  output logic [31:0] d_rdata,
  output logic        p_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_xfer,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdy
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_P = 2'd1, BUSY_D = 2'd2} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic        last_d_q;
  logic [7:0]  cnt_q;
  logic        p_done_q, d_done_q, p_err_q, d_err_q;
  logic [31:0] p_rdata_q, d_rdata_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [2:0]  mem_xfer_q;
  logic        mem_we_q, mem_re_q;
  logic        p_win_d, d_win_d, tmo_d;

  // last_d_q = 1 means debug was serviced last, so the pipeline wins the next tie
  assign p_win_d = (state_q == IDLE) & p_req & (~d_req | last_d_q);
  assign d_win_d = (state_q == IDLE) & d_req & (~p_req | ~last_d_q);
  assign tmo_d   = ~mem_rdy & (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      cnt_q       <= '0;
      p_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      p_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
      p_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_xfer_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      p_done_q <= 1'b0;
      d_done_q <= 1'b0;
      p_err_q  <= 1'b0;
      d_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (p_win_d) begin
            state_q     <= BUSY_P;
            mem_addr_q  <= p_addr;
            mem_wdata_q <= p_wdata;
            mem_xfer_q  <= p_xfer;
            mem_we_q    <= p_we;
            mem_re_q    <= ~p_we;
          end else if (d_win_d) begin
            state_q     <= BUSY_D;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_xfer_q  <= d_xfer;
            mem_we_q    <= d_we;
            mem_re_q    <= ~d_we;
          end
        end
        BUSY_P, BUSY_D: begin
          if (mem_rdy | tmo_d) begin
            state_q     <= IDLE;
            last_d_q    <= (state_q == BUSY_D);
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_xfer_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            if (state_q == BUSY_D) begin
              d_done_q <= 1'b1;
              d_err_q  <= tmo_d;
              if (tmo_d)         d_rdata_q <= '0;
              else if (mem_re_q) d_rdata_q <= mem_rdata;
            end else begin
              p_done_q <= 1'b1;
              p_err_q  <= tmo_d;
              if (tmo_d)         p_rdata_q <= '0;
              else if (mem_re_q) p_rdata_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p_gnt     = p_win_d;
  assign d_gnt     = d_win_d;
  assign p_done    = p_done_q;
  assign d_done    = d_done_q;
  assign p_err     = p_err_q;
  assign d_err     = d_err_q;
  assign p_rdata   = p_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign p_stall   = p_req & ~p_done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_xfer  = mem_xfer_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model (winner, latency, outcome).
module tb_dmem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p_req = 0, p_we = 0, d_req = 0, d_we = 0, mem_rdy = 0;
  logic [31:0] p_addr = 0, p_wdata = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [2:0]  p_xfer = 0, d_xfer = 0;
  logic        p_gnt, d_gnt, p_done, d_done, p_err, d_err, p_stall, mem_we, mem_re;
  logic [31:0] p_rdata, d_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_xfer;

  int total = 0;
  int bad = 0;
  logic        exp_last;
  logic [31:0] exp_prdata, exp_drdata;

  dmem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_xfer(p_xfer),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_xfer(d_xfer),
    .p_gnt(p_gnt), .d_gnt(d_gnt), .p_done(p_done), .d_done(d_done),
    .p_err(p_err), .d_err(d_err), .p_rdata(p_rdata), .d_rdata(d_rdata),
    .p_stall(p_stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_xfer(mem_xfer),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1; p_req = 0; d_req = 0; mem_rdy = 0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; mem_rdy = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    @(negedge clk);
    total++;
    if ({p_gnt, d_gnt, p_done, d_done, p_err, d_err, mem_we, mem_re} !== 8'h00) begin
      bad++; $display("FAIL reset_ctl: got %b want 00000000",
                      {p_gnt, d_gnt, p_done, d_done, p_err, d_err, mem_we, mem_re});
    end
    total++;
    if ({p_rdata, d_rdata, mem_addr, mem_wdata, mem_xfer} !== '0) begin
      bad++; $display("FAIL reset_data: got %h %h %h %h %h want all zero",
                      p_rdata, d_rdata, mem_addr, mem_wdata, mem_xfer);
    end
    tick();
    reset = 0; mem_rdy = 0;
  endtask

  task automatic test_single_read();
    tick();
    p_req = 1; p_we = 0; p_addr = 32'h100; p_xfer = 3'b100; d_req = 0; mem_rdy = 0;
    @(negedge clk);
    total++;
    if ({p_gnt, d_gnt, p_stall} !== 3'b101) begin
      bad++; $display("FAIL rd_gnt: got %b want 101", {p_gnt, d_gnt, p_stall});
    end
    tick();
    mem_rdy = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if ({mem_re, mem_we, mem_addr, mem_xfer, p_stall} !== {2'b10, 32'h100, 3'b100, 1'b1}) begin
      bad++; $display("FAIL rd_busy: got re=%b we=%b a=%h x=%b st=%b want 1 0 100 100 1",
                      mem_re, mem_we, mem_addr, mem_xfer, p_stall);
    end
    tick();
    mem_rdy = 0;
    @(negedge clk);
    total++;
    if ({p_done, p_err, p_stall, p_gnt, p_rdata} !== {4'b1001, 32'hDEADBEEF}) begin
      bad++; $display("FAIL rd_done: got d=%b e=%b st=%b g=%b rd=%h want 1 0 0 1 deadbeef",
                      p_done, p_err, p_stall, p_gnt, p_rdata);
    end
    tick();
    p_req = 0; mem_rdy = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    total++;
    if ({p_stall, p_done, mem_re} !== 3'b001) begin
      bad++; $display("FAIL rd2_busy: got %b want 001", {p_stall, p_done, mem_re});
    end
    tick();
    mem_rdy = 0;
    @(negedge clk);
    total++;
    if ({p_done, p_rdata} !== {1'b1, 32'h1234_5678}) begin
      bad++; $display("FAIL rd2_done: got %b %h want 1 12345678", p_done, p_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic egp, egd, edp, edd;
    tick();
    reset = 1; p_req = 1; d_req = 1; p_we = 0; d_we = 0; mem_rdy = 1;
    tick();
    reset = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      if (k >= 8) begin p_req = 0; d_req = 0; end
      mem_rdata = 32'h1000 + 32'(k);
      egp = (k < 8) && (k % 2 == 0) && ((k / 2) % 2 == 0);
      egd = (k < 8) && (k % 2 == 0) && ((k / 2) % 2 == 1);
      edp = (k >= 2) && (k <= 8) && (k % 2 == 0) && (((k - 2) / 2) % 2 == 0);
      edd = (k >= 2) && (k <= 8) && (k % 2 == 0) && (((k - 2) / 2) % 2 == 1);
      @(negedge clk);
      total++;
      if ({p_gnt, d_gnt, p_done, d_done} !== {egp, egd, edp, edd}) begin
        bad++; $display("FAIL rr_cycle%0d: got %b want %b", k,
                        {p_gnt, d_gnt, p_done, d_done}, {egp, egd, edp, edd});
      end
    end
    mem_rdy = 0;
    total++;
    if ({p_rdata, d_rdata} !== {32'h1005, 32'h1007}) begin
      bad++; $display("FAIL rr_rdata: got %h %h want 00001005 00001007", p_rdata, d_rdata);
    end
  endtask

  task automatic test_timeout();
    tick();
    d_req = 1; d_we = 0; d_addr = 32'h40; p_req = 0; mem_rdy = 0;
    tick();
    d_req = 0; mem_rdy = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rdy = 0;
    @(negedge clk);
    total++;
    if ({d_done, d_rdata} !== {1'b1, 32'hCAFEF00D}) begin
      bad++; $display("FAIL to_pre: got %b %h want 1 cafef00d", d_done, d_rdata);
    end
    tick();
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hAB; d_xfer = 3'b001;
    @(negedge clk);
    total++;
    if (d_gnt !== 1'b1) begin bad++; $display("FAIL to_gnt: got %b want 1", d_gnt); end
    for (int i = 0; i < TO; i++) begin
      tick();
      d_req = 0;
      @(negedge clk);
      total++;
      if ({mem_we, mem_re, mem_addr, mem_wdata, mem_xfer, d_done} !==
          {2'b10, 32'h20, 32'hAB, 3'b001, 1'b0}) begin
        bad++; $display("FAIL to_busy%0d: got we=%b re=%b a=%h w=%h x=%b dn=%b", i,
                        mem_we, mem_re, mem_addr, mem_wdata, mem_xfer, d_done);
      end
    end
    tick();
    @(negedge clk);
    total++;
    if ({d_done, d_err, p_err, mem_we, d_rdata} !== {4'b1100, 32'h0}) begin
      bad++; $display("FAIL to_done: got dn=%b er=%b per=%b we=%b rd=%h want 1 1 0 0 0",
                      d_done, d_err, p_err, mem_we, d_rdata);
    end
  endtask

  task automatic test_reset_busy();
    tick();
    p_req = 1; p_we = 1; p_addr = 32'h300; d_req = 0; mem_rdy = 0;
    tick();
    p_req = 0;
    tick();
    mem_rdy = 1; reset = 1;
    tick();
    reset = 0; mem_rdy = 0; d_req = 1; d_we = 1;
    @(negedge clk);
    total++;
    if ({p_done, p_err, mem_we, mem_re, d_gnt, p_rdata} !== {5'b00001, 32'h0}) begin
      bad++; $display("FAIL rst_busy: got dn=%b er=%b we=%b re=%b dg=%b rd=%h want 0 0 0 0 1 0",
                      p_done, p_err, mem_we, mem_re, d_gnt, p_rdata);
    end
    tick();
    d_req = 0; mem_rdy = 1;
    tick();
    mem_rdy = 0;
    @(negedge clk);
    total++;
    if ({d_done, p_done} !== 2'b10) begin
      bad++; $display("FAIL rst_after: got %b want 10", {d_done, p_done});
    end
  endtask

  task automatic test_req_drop();
    tick();
    p_req = 1; p_we = 0; p_addr = 32'h100; d_req = 0; mem_rdy = 0;
    tick();
    p_req = 0; p_addr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      mem_rdy = (i == 2); mem_rdata = 32'h55AA_0000;
      @(negedge clk);
      total++;
      if (mem_addr !== 32'h100) begin
        bad++; $display("FAIL drop_addr%0d: got %h want 00000100", i, mem_addr);
      end
    end
    tick();
    mem_rdy = 0;
    @(negedge clk);
    total++;
    if ({p_done, mem_addr, p_rdata} !== {1'b1, 32'h0, 32'h55AA_0000}) begin
      bad++; $display("FAIL drop_done: got %b %h %h want 1 0 55aa0000", p_done, mem_addr, p_rdata);
    end
  endtask

  task automatic test_random();
    int l, nb;
    logic pr, dr, win, ewe, enorm;
    logic [31:0] ea, ew, capt;
    logic [2:0] ex;
    do_reset();
    exp_last = 1; exp_prdata = 0; exp_drdata = 0;
    for (int it = 0; it < 40; it++) begin
      tick();
      pr = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1));
      if (!pr && !dr) pr = 1;
      p_req = pr; d_req = dr; p_we = 1'($urandom); d_we = 1'($urandom);
      p_addr = $urandom; d_addr = $urandom; p_wdata = $urandom; d_wdata = $urandom;
      p_xfer = 3'(1 << $urandom_range(0, 2)); d_xfer = 3'(1 << $urandom_range(0, 2));
      mem_rdy = 1'($urandom); mem_rdata = $urandom;
      win = (pr && dr) ? ~exp_last : ~pr;
      ea = win ? d_addr : p_addr; ew = win ? d_wdata : p_wdata;
      ex = win ? d_xfer : p_xfer; ewe = win ? d_we : p_we;
      l = $urandom_range(0, 5);
      nb = (l < TO) ? l + 1 : TO;
      enorm = (l < nb);
      capt = 0;
      @(negedge clk);
      total++;
      if ({p_gnt, d_gnt, mem_we, mem_re, p_stall} !== {~win, win, 2'b00, pr}) begin
        bad++; $display("FAIL rnd_gnt it%0d: got %b want %b", it,
                        {p_gnt, d_gnt, mem_we, mem_re, p_stall}, {~win, win, 2'b00, pr});
      end
      for (int i = 0; i < nb; i++) begin
        tick();
        p_req = 1'($urandom); d_req = 1'($urandom); p_we = 1'($urandom); d_we = 1'($urandom);
        p_addr = $urandom; d_addr = $urandom; p_wdata = $urandom; d_wdata = $urandom;
        mem_rdy = (i == l); mem_rdata = $urandom;
        if (i == l) capt = mem_rdata;
        @(negedge clk);
        total++;
        if ({mem_addr, mem_wdata, mem_xfer, mem_we, mem_re, p_gnt, d_gnt, p_done, d_done} !==
            {ea, ew, ex, ewe, ~ewe, 4'b0000}) begin
          bad++; $display("FAIL rnd_busy it%0d c%0d: got a=%h w=%h x=%b we=%b re=%b g=%b%b dn=%b%b",
                          it, i, mem_addr, mem_wdata, mem_xfer, mem_we, mem_re,
                          p_gnt, d_gnt, p_done, d_done);
        end
      end
      tick();
      p_req = 0; d_req = 0; mem_rdy = 0;
      if (!enorm) begin
        if (win) exp_drdata = 0; else exp_prdata = 0;
      end else if (!ewe) begin
        if (win) exp_drdata = capt; else exp_prdata = capt;
      end
      exp_last = win;
      @(negedge clk);
      total++;
      if ({p_done, d_done, p_err, d_err, mem_we, mem_re, p_rdata, d_rdata} !==
          {~win, win, ~win & ~enorm, win & ~enorm, 2'b00, exp_prdata, exp_drdata}) begin
        bad++; $display("FAIL rnd_done it%0d: got dn=%b%b er=%b%b rd=%h/%h want dn=%b%b er=%b%b rd=%h/%h",
                        it, p_done, d_done, p_err, d_err, p_rdata, d_rdata,
                        ~win, win, ~win & ~enorm, win & ~enorm, exp_prdata, exp_drdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_reset_busy();
    test_req_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of BUSY cycles waited for mem_rdy before an access is aborted (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports p_req/p_we, input, 1 each; pipeline access request and write (1) or read (0).
REQ-005 SHALL have ports p_addr/p_wdata, input, 32 each, and p_xfer, input, 3; pipeline address, write data and transfer size (001 byte, 010 half, 100 word).
REQ-006 SHALL have ports d_req/d_we, input, 1 each; d_addr/d_wdata, input, 32 each; d_xfer, input, 3; the same fields for the debug/loader requester.
REQ-007 SHALL have ports p_gnt/d_gnt, output, 1 each; one-cycle acceptance pulse.
REQ-008 SHALL have ports p_done/d_done, output, 1 each; one-cycle completion pulse.
REQ-009 SHALL have ports p_err/d_err, output, 1 each; timeout pulse, coincident with done.
REQ-010 SHALL have ports p_rdata/d_rdata, output, 32 each; read data, held until that requester's next completion.
REQ-011 SHALL have port p_stall, output, 1; pipeline halt request.
REQ-012 SHALL have ports mem_addr/mem_wdata, output, 32 each; mem_xfer, output, 3; mem_we/mem_re, output, 1 each; drive the data memory.
REQ-013 SHALL have ports mem_rdata, input, 32, and mem_rdy, input, 1; memory read data and completion strobe.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY_P, BUSY_D.
REQ-015 IDLE: if only one req high, SHALL grant it; if both high, SHALL grant the requester not granted last (round-robin via last_grant bit).
REQ-016 Grant: gnt pulse combinational in the IDLE cycle of acceptance; addr/wdata/xfer/we latched into internal registers at that edge; next state BUSY_P or BUSY_D.
REQ-017 BUSY: mem_addr/mem_wdata/mem_xfer from latched registers; mem_we = latched we; mem_re = ~latched we; mem_we and mem_re SHALL both be 0 in IDLE, mem_addr/wdata/xfer 0 in IDLE.
REQ-018 BUSY with mem_rdy=1: next edge -> IDLE, done pulse high the following cycle, rdata <= mem_rdata on reads (unchanged on writes), last_grant <= serviced requester.
REQ-019 Wait counter (8 bit) SHALL clear on entry to BUSY and increment each BUSY cycle with mem_rdy=0.
REQ-020 Counter == TIMEOUT-1 with mem_rdy=0: next edge -> IDLE, done and err both pulse, rdata <= 0, last_grant updated.
REQ-021 mem_rdy in IDLE SHALL be ignored; mem_rdy on the timeout cycle SHALL win (normal completion, no err).
REQ-022 Minimum latency: request high in cycle N (IDLE) -> BUSY in N+1, mem_rdy in N+1 -> done in N+2; a new grant SHALL be possible in N+2 (done cycle is IDLE).
REQ-023 req deasserted during BUSY SHALL NOT abort the access; inputs changed during BUSY SHALL NOT affect memory outputs.
REQ-024 p_stall = p_req & ~p_done (combinational); SHALL be 0 whenever p_req is 0.
REQ-025 At most one gnt, one done, and one of mem_we/mem_re SHALL be high in any cycle.

Reset
REQ-026 reset high at a clock edge SHALL force IDLE, counter 0, last_grant = debug (pipeline wins first tie), all gnt/done/err 0, p_rdata/d_rdata 0, mem_we/mem_re 0.
REQ-027 reset during BUSY SHALL abandon the access with no done or err pulse; reset overrides mem_rdy in the same cycle.

Verification
REQ-028 p_req=1, p_we=0, p_addr=0x100, p_xfer=100; mem_rdy=1 one cycle after grant with mem_rdata=0xDEADBEEF -> p_gnt in cycle 0, mem_re=1 in cycle 1, p_done=1 and p_rdata=0xDEADBEEF in cycle 2, p_stall low in cycle 2.
REQ-029 p_req and d_req both held high from reset, mem_rdy=1 always -> grants alternate P,D,P,D; each done 2 cycles after its gnt.
REQ-030 d_req write 0x0000_00AB to 0x20, xfer=001, mem_rdy held 0, TIMEOUT=4 -> after 4 BUSY cycles d_done=1 and d_err=1, d_rdata=0, mem_we drops.
REQ-031 reset asserted in the second BUSY_P cycle with mem_rdy=1 -> next cycle IDLE, no p_done, mem_we=mem_re=0, p_rdata=0.
REQ-032 p_req dropped one cycle after grant, p_addr changed to 0x200 -> mem_addr stays 0x100 until completion, p_done still pulses.
